// File: rtl/hazard_pkg.sv
// Purpose : shared types and constants for the pipeline hazard controller.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package hazard_pkg;

   // Sequencer states: normal flow, waiting on data memory, halted after timeout.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   // Default number of MEM_WAIT cycles allowed before the core halts.
   localparam int TIMEOUT_DEF = 15;

   // Default width of the performance counters.
   localparam int CNT_W_DEF = 32;

   // Register x0 is hard-wired zero, so a load targeting it never creates a hazard.
   localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Purpose : up-counter that sticks at all-ones instead of wrapping.
// Latency : count updates on the clock edge after inc_i is sampled high.
// Backpressure : none; inc_i is honoured every cycle until saturation.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous clear, active-low
//   inc_i  - add one this cycle (ignored once saturated)
//   cnt_o  - current count
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : 5-stage pipeline sequencer: load-use bubbles, taken-branch flushes, dmem req/ack wait.
// Latency : enables/flushes are combinational from state and inputs; state moves on the next edge.
// Backpressure : dmem_ack_i low freezes every pipeline register; TIMEOUT waits without ack halts the core.
//
// Ports:
//   clk_i, rst_i                        - clock and asynchronous active-low reset
//   ifid_rs1_i/rs2_i, ifid_use_rs*_i     - source operands of the instruction in IF/ID
//   idex_rd_i, idex_memread_i           - destination and load flag of the instruction in ID/EX
//   mem_access_i, dmem_ack_i, dmem_req_o - data memory handshake for the instruction in EX/MEM
//   branch_taken_i                      - taken branch resolved in MEM
//   *_en_o, *_flush_o                   - per-stage register write-enables and NOP-load controls
//   halt_o                              - core halted on memory timeout (sticky until reset)
//   stall_cnt_o, flush_cnt_o            - saturating bubble/wait and taken-branch counters
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ifid_rs1_i,
   input  logic [4:0]       ifid_rs2_i,
   input  logic             ifid_use_rs1_i,
   input  logic             ifid_use_rs2_i,
   input  logic [4:0]       idex_rd_i,
   input  logic             idex_memread_i,
   input  logic             mem_access_i,
   input  logic             branch_taken_i,
   input  logic             dmem_ack_i,
   output logic             dmem_req_o,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             idex_en_o,
   output logic             exmem_en_o,
   output logic             memwb_en_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             exmem_flush_o,
   output logic             halt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;

   state_t            w_state_nxt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              w_lu;
   logic              w_stall_inc;
   logic              w_flush_inc;
   logic              w_pc_en;
   logic              w_ifid_en;
   logic              w_idex_en;
   logic              w_exmem_en;
   logic              w_memwb_en;
   logic              w_ifid_flush;
   logic              w_idex_flush;
   logic              w_exmem_flush;
   logic              w_req;
   logic              w_halt;

   // Load in EX whose result is needed by the instruction in ID.
   assign w_lu = idex_memread_i && (idex_rd_i != X0) &&
                 ((ifid_use_rs1_i && (idex_rd_i == ifid_rs1_i)) ||
                  (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));

   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_en    = 1'b0;
      w_memwb_en    = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_flush = 1'b0;
      w_req         = 1'b0;
      w_halt        = 1'b0;

      case (r_state)
         RUN: begin
            w_req = mem_access_i;
            if (mem_access_i && !dmem_ack_i) begin
               // First cycle of a slow access: freeze and count it as a wait cycle.
               w_stall_inc = 1'b1;
               w_state_nxt = MEM_WAIT;
               w_wait_nxt  = WAIT_W'(1);
            end else begin
               w_pc_en    = 1'b1;
               w_ifid_en  = 1'b1;
               w_idex_en  = 1'b1;
               w_exmem_en = 1'b1;
               w_memwb_en = 1'b1;
               if (branch_taken_i) begin
                  // Squash the three wrong-path instructions; any load-use stall on them is moot.
                  w_ifid_flush  = 1'b1;
                  w_idex_flush  = 1'b1;
                  w_exmem_flush = 1'b1;
                  w_flush_inc   = 1'b1;
               end else if (w_lu) begin
                  w_pc_en      = 1'b0;
                  w_ifid_en    = 1'b0;
                  w_idex_flush = 1'b1;
                  w_stall_inc  = 1'b1;
               end
            end
         end

         MEM_WAIT: begin
            // EX/MEM holds the pending load/store, not a branch, so branch_taken_i is
            // meaningless here; only the load-use bubble can apply on the ack cycle.
            w_req = 1'b1;
            if (dmem_ack_i) begin
               w_pc_en     = 1'b1;
               w_ifid_en   = 1'b1;
               w_idex_en   = 1'b1;
               w_exmem_en  = 1'b1;
               w_memwb_en  = 1'b1;
               w_state_nxt = RUN;
               w_wait_nxt  = '0;
               if (w_lu) begin
                  w_pc_en      = 1'b0;
                  w_ifid_en    = 1'b0;
                  w_idex_flush = 1'b1;
                  w_stall_inc  = 1'b1;
               end
            end else begin
               w_stall_inc = 1'b1;
               if (r_wait_cnt == WAIT_W'(TIMEOUT)) begin
                  w_state_nxt = HALT;
               end else begin
                  w_wait_nxt = r_wait_cnt + WAIT_W'(1);
               end
            end
         end

         HALT: begin
            w_halt = 1'b1;
         end

         default: begin
            w_state_nxt = HALT;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Reset gates every control output directly so a pending request drops at once.
   assign dmem_req_o    = w_req         & rst_i;
   assign pc_en_o       = w_pc_en       & rst_i;
   assign ifid_en_o     = w_ifid_en     & rst_i;
   assign idex_en_o     = w_idex_en     & rst_i;
   assign exmem_en_o    = w_exmem_en    & rst_i;
   assign memwb_en_o    = w_memwb_en    & rst_i;
   assign ifid_flush_o  = w_ifid_flush  & rst_i;
   assign idex_flush_o  = w_idex_flush  & rst_i;
   assign exmem_flush_o = w_exmem_flush & rst_i;
   assign halt_o        = w_halt        & rst_i;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (w_stall_inc),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (w_flush_inc),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed bench for hazard_ctrl with a cycle-level reference model and literal spot checks.
// Latency : outputs compared every falling edge; model advances with the DUT.
// Backpressure : n/a.
module tb_hazard_ctrl;

   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic use1 = 1'b0, use2 = 1'b0, memread = 1'b0;
   logic mem = 1'b0, br = 1'b0, ack = 1'b0;

   // 32-bit counter instance
   logic req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_fl, idex_fl, exmem_fl, halt;
   logic [31:0] stall_cnt, flush_cnt;
   // 4-bit counter instance (saturation)
   logic req_s, pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
   logic ifid_fl_s, idex_fl_s, exmem_fl_s, halt_s;
   logic [3:0] stall_cnt_s, flush_cnt_s;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(32), .TIMEOUT(TO)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_use_rs1_i(use1), .ifid_use_rs2_i(use2),
      .idex_rd_i(rd), .idex_memread_i(memread), .mem_access_i(mem),
      .branch_taken_i(br), .dmem_ack_i(ack), .dmem_req_o(req),
      .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en),
      .exmem_en_o(exmem_en), .memwb_en_o(memwb_en),
      .ifid_flush_o(ifid_fl), .idex_flush_o(idex_fl), .exmem_flush_o(exmem_fl),
      .halt_o(halt), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   hazard_ctrl #(.CNT_W(4), .TIMEOUT(TO)) u_dut4 (
      .clk_i(clk), .rst_i(rst),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_use_rs1_i(use1), .ifid_use_rs2_i(use2),
      .idex_rd_i(rd), .idex_memread_i(memread), .mem_access_i(mem),
      .branch_taken_i(br), .dmem_ack_i(ack), .dmem_req_o(req_s),
      .pc_en_o(pc_en_s), .ifid_en_o(ifid_en_s), .idex_en_o(idex_en_s),
      .exmem_en_o(exmem_en_s), .memwb_en_o(memwb_en_s),
      .ifid_flush_o(ifid_fl_s), .idex_flush_o(idex_fl_s), .exmem_flush_o(exmem_fl_s),
      .halt_o(halt_s), .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
   );

   wire [4:0] en_v   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   wire [2:0] fl_v   = {ifid_fl, idex_fl, exmem_fl};
   wire [4:0] en_v_s = {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s};
   wire [2:0] fl_v_s = {ifid_fl_s, idex_fl_s, exmem_fl_s};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pipeline view: "waiting" = a data access is outstanding and has seen m_waited
   // un-acked cycles; "halted" = memory never answered; counters as plain integers.
   bit      m_halted  = 1'b0;
   bit      m_waiting = 1'b0;
   int      m_waited  = 0;
   longint  m_stall   = 0;
   longint  m_flush   = 0;

   always @(negedge clk) begin : cmp
      logic [4:0] e_en;
      logic [2:0] e_fl;
      logic e_req, e_halt, lu, frozen, stall_now, flush_now;
      longint sat4_stall, sat4_flush;

      lu = memread && (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
      e_en = '0; e_fl = '0; e_req = 1'b0; e_halt = 1'b0;
      frozen = 1'b0; stall_now = 1'b0; flush_now = 1'b0;

      if (!rst) begin
         m_halted = 1'b0; m_waiting = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0;
      end else if (m_halted) begin
         e_halt = 1'b1;
      end else begin
         e_req  = m_waiting || mem;
         frozen = (m_waiting || mem) && !ack;
         if (frozen) begin
            stall_now = 1'b1;
         end else begin
            e_en = 5'b11111;
            if (br && !m_waiting) begin
               e_fl = 3'b111;
               flush_now = 1'b1;
            end else if (lu) begin
               e_en = 5'b00111;
               e_fl = 3'b010;
               stall_now = 1'b1;
            end
         end
      end

      sat4_stall = (m_stall > 15) ? 15 : m_stall;
      sat4_flush = (m_flush > 15) ? 15 : m_flush;
      check("en",        64'(en_v),        64'(e_en));
      check("flush",     64'(fl_v),        64'(e_fl));
      check("req",       64'(req),         64'(e_req));
      check("halt",      64'(halt),        64'(e_halt));
      check("stall_cnt", 64'(stall_cnt),   64'(m_stall));
      check("flush_cnt", 64'(flush_cnt),   64'(m_flush));
      check("en_s",      64'({en_v_s, fl_v_s, req_s, halt_s}),
                         64'({e_en, e_fl, e_req, e_halt}));
      check("stall_s",   64'(stall_cnt_s), 64'(sat4_stall));
      check("flush_s",   64'(flush_cnt_s), 64'(sat4_flush));

      if (rst && !m_halted) begin
         if (frozen) begin
            if (m_waiting && m_waited == TO) m_halted = 1'b1;
            else begin
               m_waiting = 1'b1;
               m_waited  = m_waited + 1;
            end
         end else begin
            m_waiting = 1'b0;
            m_waited  = 0;
         end
         if (stall_now) m_stall++;
         if (flush_now) m_flush++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic u1, input logic u2,
                        input logic m, input logic a, input logic b);
      memread = mr; rd = d; rs1 = s1; rs2 = s2; use1 = u1; use2 = u2;
      mem = m; ack = a; br = b;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      idle();
      repeat (2) tick();
      @(negedge clk);
      check("lit_rst_en",   64'(en_v), 64'd0);
      check("lit_rst_halt", 64'(halt), 64'd0);
      tick();
      rst = 1'b1;

      // idle running
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lit_idle_en", 64'(en_v), 64'h1f);
         tick();
      end
      check("lit_idle_stall", 64'(stall_cnt), 64'd0);

      // lw x5 ; add x6,x5,x1
      drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("lit_lu_en", 64'(en_v), 64'b00111);
      check("lit_lu_fl", 64'(fl_v), 64'b010);
      tick();
      idle();
      @(negedge clk);
      check("lit_lu_cnt", 64'(stall_cnt), 64'd1);
      check("lit_lu_after", 64'(en_v), 64'h1f);
      tick();

      // rd = x0 matching rs1, then rs2 match with use_rs2 = 0
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("lit_x0", 64'(en_v), 64'h1f);
      tick();
      drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("lit_nouse2", 64'(en_v), 64'h1f);
      tick();

      // taken branch
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("lit_br_fl", 64'(fl_v), 64'b111);
      check("lit_br_pc", 64'(pc_en), 64'd1);
      tick();
      idle();
      @(negedge clk);
      check("lit_br_cnt", 64'(flush_cnt), 64'd1);
      tick();

      // branch together with load-use: flush only
      drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("lit_brlu_en", 64'(en_v), 64'h1f);
      tick();
      idle();
      @(negedge clk);
      check("lit_brlu_stall", 64'(stall_cnt), 64'd1);
      check("lit_brlu_flush", 64'(flush_cnt), 64'd2);
      tick();

      // access acked on its fourth cycle
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, (c == 3), 1'b0);
         @(negedge clk);
         check("lit_mw_req", 64'(req), 64'd1);
         check("lit_mw_en",  64'(en_v), (c == 3) ? 64'h1f : 64'h0);
         tick();
      end
      idle();
      @(negedge clk);
      check("lit_mw_stall", 64'(stall_cnt), 64'd4);
      tick();

      // zero-wait access
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("lit_zw_en", 64'(en_v), 64'h1f);
      tick();

      // ack exactly on wait cycle 15: no halt
      for (int c = 0; c <= TO; c++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, (c == TO), 1'b0);
         tick();
      end
      idle();
      @(negedge clk);
      check("lit_late_halt",  64'(halt), 64'd0);
      check("lit_late_en",    64'(en_v), 64'h1f);
      check("lit_late_stall", 64'(stall_cnt), 64'd19);
      tick();

      // no ack: timeout into HALT, which ignores later acks
      for (int c = 0; c <= TO; c++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         check("lit_halt",     64'(halt), 64'd1);
         check("lit_halt_req", 64'(req), 64'd0);
         check("lit_halt_en",  64'(en_v), 64'd0);
         tick();
      end
      check("lit_halt_stall", 64'(stall_cnt), 64'd35);

      // reset out of HALT
      idle();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();

      // asynchronous reset while waiting on memory
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      #2;
      check("lit_wait_req", 64'(req), 64'd1);
      rst = 1'b0;
      #1;
      check("lit_arst_req", 64'(req), 64'd0);
      check("lit_arst_cnt", 64'(stall_cnt), 64'd0);
      tick();
      rst = 1'b1;

      // saturation of the 4-bit stall counter
      drive(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (20) tick();
      idle();
      @(negedge clk);
      check("lit_sat4",  64'(stall_cnt_s), 64'd15);
      check("lit_sat32", 64'(stall_cnt), 64'd20);
      tick();
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
